evm_ballot_controller: RTL and testbench



---
 rtl/evm_pkg.sv | 39 +++
 rtl/evm_vote_counter_bank.sv | 73 +++++++
 rtl/evm_ballot_controller.sv | 153 +++++++++++++++
 tb/tb_evm_ballot_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | evm_pkg: ballot FSM encoding, default sizes and bit-vector helpers.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package evm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CAST  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int N_CAND_DEF = 4;
  localparam int CNT_W_DEF  = 8;
  localparam int MAX_CAND   = 32;

  function automatic logic [MAX_CAND-1:0] onehot(input int unsigned idx);
    logic [MAX_CAND-1:0] v;
    for (int i = 0; i < MAX_CAND; i++) begin
      v[i] = (idx == unsigned'(i));
    end
    return v;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_CAND-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (v[i]) begin
        cnt++;
      end
    end
    return cnt;
  endfunction

endpackage : evm_pkg
`default_nettype wire

// File: rtl/evm_vote_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | evm_vote_counter_bank: saturating per-candidate and total vote       |
// | counters with a registered result readout.                          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module evm_vote_counter_bank
  import evm_pkg::*;
#(
  parameter int N_CAND = N_CAND_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CAND-1:0] inc,
  input  logic              result_mode,
  input  logic [SEL_W-1:0]  result_sel,
  output logic [CNT_W-1:0]  result_count,
  output logic [CNT_W-1:0]  total_votes
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count [N_CAND];
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_result;
  logic [CNT_W-1:0] w_sel_count;

  // Saturation is tested before the add so a full counter never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) begin
        r_count[i] <= '0;
      end
      r_total <= '0;
    end else begin
      for (int i = 0; i < N_CAND; i++) begin
        if (inc[i] && (r_count[i] != c_cnt_max)) begin
          r_count[i] <= r_count[i] + CNT_W'(1);
        end
      end
      if ((|inc) && (r_total != c_cnt_max)) begin
        r_total <= r_total + CNT_W'(1);
      end
    end
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    w_sel_count = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (result_sel == SEL_W'(i)) begin
        w_sel_count = r_count[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
    end else if (!result_mode) begin
      r_result <= '0;
    end else begin
      r_result <= w_sel_count;
    end
  end

  assign result_count = r_result;
  assign total_votes  = r_total;

endmodule : evm_vote_counter_bank
`default_nettype wire

// File: rtl/evm_ballot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | evm_ballot_controller: one-ballot-per-enable sequencer with button  |
// | arbitration, timeout, confirmation hold and results readout.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module evm_ballot_controller
  import evm_pkg::*;
#(
  parameter int N_CAND      = N_CAND_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SEL_W       = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ballot_en,
  input  logic [N_CAND-1:0] cand_pulse,
  input  logic              result_mode,
  input  logic [SEL_W-1:0]  result_sel,
  output logic              ready,
  output logic [N_CAND-1:0] vote_led,
  output logic [N_CAND-1:0] vote_inc,
  output logic              invalid,
  output logic              timeout,
  output logic [CNT_W-1:0]  result_count,
  output logic [CNT_W-1:0]  total_votes
);

  // One timer serves both the ARMED timeout and the HOLD duration.
  localparam int TMR_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] c_timeout_last = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] c_hold_last    = TMR_W'(HOLD_CYCLES - 1);

  state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]  r_tmr, w_tmr_nxt;
  logic [SEL_W-1:0]  r_idx, w_idx_nxt;
  logic              r_invalid, w_invalid_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [SEL_W-1:0]  w_press_idx;
  int unsigned       w_npress;
  logic [N_CAND-1:0] w_idx_oh;
  logic [N_CAND-1:0] w_commit_oh;

  always_comb begin
    w_npress = popcount(MAX_CAND'(cand_pulse));
  end

  always_comb begin
    w_press_idx = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (cand_pulse[i]) begin
        w_press_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_idx_oh = N_CAND'(onehot(32'(r_idx)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tmr     <= '0;
      r_idx     <= '0;
      r_invalid <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_idx     <= w_idx_nxt;
      r_invalid <= w_invalid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr;
    w_idx_nxt     = r_idx;
    w_invalid_nxt = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tmr_nxt = '0;
        if (ballot_en && !result_mode) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        w_tmr_nxt = r_tmr + TMR_W'(1);
        // Closing the poll discards the ballot silently; a valid press beats expiry.
        if (result_mode) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end else if (w_npress == 1) begin
          w_state_nxt = ST_CAST;
          w_idx_nxt   = w_press_idx;
          w_tmr_nxt   = '0;
        end else begin
          w_invalid_nxt = (w_npress > 1);
          if (r_tmr == c_timeout_last) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
            w_tmr_nxt     = '0;
          end
        end
      end
      ST_CAST: begin
        w_state_nxt = ST_HOLD;
        w_tmr_nxt   = '0;
      end
      ST_HOLD: begin
        w_tmr_nxt = r_tmr + TMR_W'(1);
        if (r_tmr == c_hold_last) begin
          w_state_nxt = ST_IDLE;
          w_tmr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  assign w_commit_oh = (r_state == ST_CAST) ? w_idx_oh : '0;

  evm_vote_counter_bank #(
    .N_CAND (N_CAND),
    .CNT_W  (CNT_W),
    .SEL_W  (SEL_W)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .inc          (w_commit_oh),
    .result_mode  (result_mode),
    .result_sel   (result_sel),
    .result_count (result_count),
    .total_votes  (total_votes)
  );

  assign ready    = (r_state == ST_ARMED);
  assign vote_inc = w_commit_oh;
  assign vote_led = (r_state == ST_HOLD) ? w_idx_oh : '0;
  assign invalid  = r_invalid;
  assign timeout  = r_timeout;

endmodule : evm_ballot_controller
`default_nettype wire

// File: tb/tb_evm_ballot_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_evm_ballot_controller: directed self-checking bench.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_evm_ballot_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       ballot_en;
  logic [3:0] cand_pulse;
  logic       result_mode;
  logic [1:0] result_sel;
  logic       ready;
  logic [3:0] vote_led;
  logic [3:0] vote_inc;
  logic       invalid;
  logic       timeout;
  logic [7:0] result_count;
  logic [7:0] total_votes;

  int checks   = 0;
  int failures = 0;
  int seen_bad = 0;

  evm_ballot_controller #(
    .N_CAND      (4),
    .CNT_W       (8),
    .SEL_W       (2),
    .HOLD_CYCLES (4),
    .TIMEOUT     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ballot_en    (ballot_en),
    .cand_pulse   (cand_pulse),
    .result_mode  (result_mode),
    .result_sel   (result_sel),
    .ready        (ready),
    .vote_led     (vote_led),
    .vote_inc     (vote_inc),
    .invalid      (invalid),
    .timeout      (timeout),
    .result_count (result_count),
    .total_votes  (total_votes)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cast_vote(input int idx);
    ballot_en = 1'b1;
    tick();
    ballot_en  = 1'b0;
    cand_pulse = 4'b0001 << idx;
    tick();
    cand_pulse = 4'b0000;
    repeat (5) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ballot_en = 1'b0; cand_pulse = '0; result_mode = 1'b0; result_sel = '0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_ready", ready, 0);
    check("rst_led", vote_led, 0);
    check("rst_inc", vote_inc, 0);
    check("rst_invalid", invalid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result", result_count, 0);
    check("rst_total", total_votes, 0);

    // Single vote for candidate 2, pressed two cycles after ballot_en.
    ballot_en = 1'b1;
    tick();
    check("sv_ready", ready, 1);
    ballot_en = 1'b0;
    tick();
    cand_pulse = 4'b0100;
    tick();
    check("sv_inc", vote_inc, 4'b0100);
    check("sv_cast_ready", ready, 0);
    check("sv_cast_led", vote_led, 0);
    cand_pulse = 4'b0000;
    tick();
    check("sv_led1", vote_led, 4'b0100);
    check("sv_inc_off", vote_inc, 0);
    check("sv_total", total_votes, 1);
    cand_pulse = 4'b0001;
    tick();
    check("hold_guard_inc", vote_inc, 0);
    check("sv_led2", vote_led, 4'b0100);
    cand_pulse = 4'b0000;
    tick();
    check("sv_led3", vote_led, 4'b0100);
    tick();
    check("sv_led4", vote_led, 4'b0100);
    tick();
    check("sv_led_end", vote_led, 0);
    check("sv_idle_ready", ready, 0);

    // Press in IDLE without ballot_en is ignored.
    cand_pulse = 4'b0001;
    tick();
    cand_pulse = 4'b0000;
    check("idle_guard_inc", vote_inc, 0);
    check("idle_guard_ready", ready, 0);
    tick();
    check("idle_guard_inc2", vote_inc, 0);
    check("guard_total", total_votes, 1);

    // Multi-press rejected, then single press for candidate 1.
    ballot_en = 1'b1;
    tick();
    ballot_en  = 1'b0;
    cand_pulse = 4'b0011;
    tick();
    check("mp_invalid", invalid, 1);
    check("mp_ready", ready, 1);
    check("mp_no_inc", vote_inc, 0);
    cand_pulse = 4'b0000;
    tick();
    check("mp_invalid_off", invalid, 0);
    check("mp_ready2", ready, 1);
    cand_pulse = 4'b0010;
    tick();
    check("mp_inc", vote_inc, 4'b0010);
    cand_pulse = 4'b0000;
    repeat (5) tick();
    check("mp_total", total_votes, 2);

    // Readout; ballot_en is ignored while the poll is closed.
    result_mode = 1'b1; result_sel = 2'd2;
    tick();
    check("rd_c2", result_count, 1);
    result_sel = 2'd1;
    tick();
    check("rd_c1", result_count, 1);
    result_sel = 2'd0; ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    check("rd_c0", result_count, 0);
    check("rd_no_arm", ready, 0);
    result_mode = 1'b0; result_sel = 2'd2;
    tick();
    check("rd_closed", result_count, 0);

    // Timeout with a stray ballot_en mid-wait that must not restart the timer.
    ballot_en = 1'b1;
    tick();
    check("to_ready0", ready, 1);
    for (int k = 1; k <= 15; k++) begin
      ballot_en = (k == 5);
      tick();
      if (ready !== 1'b1 || timeout !== 1'b0) seen_bad++;
    end
    ballot_en = 1'b0;
    check("to_wait", seen_bad, 0);
    tick();
    check("to_pulse", timeout, 1);
    check("to_ready_drop", ready, 0);
    tick();
    check("to_pulse_off", timeout, 0);
    check("to_total", total_votes, 2);

    // Press exactly on the expiry cycle wins.
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    repeat (15) tick();
    check("ex_ready", ready, 1);
    cand_pulse = 4'b1000;
    tick();
    check("ex_inc", vote_inc, 4'b1000);
    check("ex_no_to", timeout, 0);
    cand_pulse = 4'b0000;
    tick();
    check("ex_no_to2", timeout, 0);
    check("ex_led", vote_led, 4'b1000);
    check("ex_total", total_votes, 3);
    repeat (4) tick();
    check("ex_idle_led", vote_led, 0);

    // Saturation: candidate 3 receives 256 more votes.
    for (int v = 0; v < 256; v++) cast_vote(3);
    result_mode = 1'b1; result_sel = 2'd3;
    tick();
    check("sat_c3", result_count, 255);
    check("sat_total", total_votes, 255);
    result_sel = 2'd2;
    tick();
    check("sat_c2", result_count, 1);
    result_mode = 1'b0;
    tick();

    // Reset asserted during HOLD.
    ballot_en = 1'b1;
    tick();
    ballot_en  = 1'b0;
    cand_pulse = 4'b0001;
    tick();
    cand_pulse = 4'b0000;
    tick();
    check("rh_led", vote_led, 4'b0001);
    reset = 1'b1;
    tick();
    check("rh_led0", vote_led, 0);
    check("rh_total0", total_votes, 0);
    check("rh_ready0", ready, 0);
    check("rh_inc0", vote_inc, 0);
    reset = 1'b0; result_mode = 1'b1; result_sel = 2'd3;
    tick();
    check("rh_result0", result_count, 0);
    result_mode = 1'b0;

    // Closing the poll while ARMED discards the ballot.
    ballot_en = 1'b1;
    tick();
    ballot_en = 1'b0;
    check("rm_ready", ready, 1);
    result_mode = 1'b1; cand_pulse = 4'b0001;
    tick();
    check("rm_ready_drop", ready, 0);
    check("rm_no_inc", vote_inc, 0);
    check("rm_no_to", timeout, 0);
    result_mode = 1'b0; cand_pulse = 4'b0000;
    seen_bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (timeout !== 1'b0 || vote_inc !== 4'b0000 || ready !== 1'b0) seen_bad++;
    end
    check("rm_quiet", seen_bad, 0);
    check("rm_total", total_votes, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_evm_ballot_controller
`default_nettype wire
